// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default UART_TX settings.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SEND   = 2'd2
  } arb_state_t;

  localparam int unsigned UART_CLOCK_HZ = 50_000_000;
  localparam int unsigned UART_BAUD     = 115_200;

  // Clock cycles per UART bit for a given clock and baud rate.
  function automatic int unsigned uart_clks_per_bit(input int unsigned clock_hz,
                                                    input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   Valid_i;
  logic [8*N-1:0] Data_i;
  logic [N-1:0]   Last_i;
  logic [N-1:0]   Ready_o;
  logic [N-1:0]   Grant_o;
  logic           UartStart_o;
  logic [7:0]     UartData_o;
  logic           UartBusy_i;
  logic           UartDone_i;
  logic           Timeout_o;

  // Arbiter view.
  modport slave (
    input  Valid_i, Data_i, Last_i, UartBusy_i, UartDone_i,
    output Ready_o, Grant_o, UartStart_o, UartData_o, Timeout_o
  );

  // Requester / UART side view.
  modport master (
    output Valid_i, Data_i, Last_i, UartBusy_i, UartDone_i,
    input  Ready_o, Grant_o, UartStart_o, UartData_o, Timeout_o
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after ptr, wrapping mod N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan ptr+1 .. ptr+N so the last owner is considered last.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] pos;
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      pos = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[pos]) begin
        found        = 1'b1;
        grant_c[pos] = 1'b1;
        idx_c        = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART_TX among N byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_W      = 20
) (
  input logic               Clock,
  input logic               Reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_t           state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;
  logic                 timeout_q, timeout_d;
  logic [N-1:0]         ready_c;
  logic [N-1:0]         pick_grant_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 owner_valid_c;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (bus.Valid_i),
    .ptr     (ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c)
  );

  assign owner_valid_c = bus.Valid_i[idx_q];

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(N - 1);
      cnt_q     <= '0;
      last_q    <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      start_q   <= start_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, lock bookkeeping and combinational Ready.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    start_d   = 1'b0;
    data_d    = data_q;
    timeout_d = 1'b0;
    ready_c   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.Valid_i) begin
          grant_d = pick_grant_c;
          idx_d   = pick_idx_c;
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!bus.UartBusy_i) ready_c = grant_q;
        if (owner_valid_c && !bus.UartBusy_i) begin
          data_d  = bus.Data_i[8*int'(idx_q) +: 8];
          last_d  = bus.Last_i[idx_q];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end else if (!owner_valid_c) begin
          if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            ptr_d     = idx_q;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (bus.UartDone_i) begin
          if (last_q) begin
            ptr_d   = idx_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Ready_o     = ready_c;
  assign bus.Grant_o     = grant_q;
  assign bus.UartStart_o = start_q;
  assign bus.UartData_o  = data_q;
  assign bus.Timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART_TX and requester queues.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned TW    = 5;
  localparam int unsigned FRAME = 5;

  typedef struct packed { logic [7:0] data; logic last; } pkt_t;
  typedef struct packed { logic [1:0] req; logic [7:0] data; } exp_t;
  typedef struct { logic [3:0] mask; logic [3:0] exp_grant; } vec_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic busy_m = 1'b0;
  logic done_m = 1'b0;
  logic force_busy = 1'b0;
  int   fcnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   to_cnt = 0;
  int   to_cyc = 0;
  int   ret_cyc = 0;
  logic [N-1:0] acc = '0;
  logic [N-1:0] drv_v;
  logic [8*N-1:0] drv_d;
  logic [N-1:0] drv_l;

  pkt_t rq [N][$];
  exp_t exp_q [$];
  vec_t vecs [8];

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(TW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.UartBusy_i = busy_m | force_busy;
  assign bus.UartDone_i = done_m;

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  function automatic bit idle();
    bit r;
    r = (exp_q.size() == 0) && (bus.Grant_o == '0);
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_grant(input string name, input logic [3:0] exp);
    int i;
    i = 0;
    while (bus.Grant_o == '0 && i < 50) begin tick(); i++; end
    check(name, 32'(bus.Grant_o), 32'(exp));
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (!idle() && i < 500) begin tick(); i++; end
    check(name, 32'(idle()), 32'd1);
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back({d, l});
    exp_q.push_back({2'(k), d});
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    force_busy = 1'b0;
    for (int k = 0; k < N; k++) rq[k].delete();
    exp_q.delete();
    tick(); tick();
    Reset = 1'b1;
    tick();
  endtask

  // Cycle counter.
  always @(posedge Clock) cyc <= cyc + 1;

  // Accepted-byte capture, sampled with pre-edge values.
  always @(posedge Clock) acc <= bus.Valid_i & bus.Ready_o;

  // Requester driver: pop accepted bytes, present queue heads.
  always @(posedge Clock) begin
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k] && rq[k].size() != 0) void'(rq[k].pop_front());
    drv_v = '0; drv_d = '0; drv_l = '0;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() != 0) begin
        drv_v[k]         = 1'b1;
        drv_d[8*k +: 8]  = rq[k][0].data;
        drv_l[k]         = rq[k][0].last;
      end
    end
    bus.Valid_i = drv_v;
    bus.Data_i  = drv_d;
    bus.Last_i  = drv_l;
  end

  // Behavioural UART_TX: Busy for FRAME cycles after Start, then a Done pulse.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy_m = 1'b0;
      done_m = 1'b0;
      fcnt   = 0;
    end else begin
      #1;
      done_m = 1'b0;
      if (bus.UartStart_o) begin
        busy_m = 1'b1;
        fcnt   = FRAME;
      end else if (busy_m) begin
        fcnt--;
        if (fcnt == 0) begin
          busy_m = 1'b0;
          done_m = 1'b1;
        end
      end
    end
  end

  // Output monitor and scoreboard.
  always @(negedge Clock) begin
    if (Reset) begin
      exp_t e;
      check("ready_subset_of_grant", 32'(bus.Ready_o & ~bus.Grant_o), 32'd0);
      check("grant_onehot0", 32'($onehot0(bus.Grant_o)), 32'd1);
      if (bus.UartStart_o) begin
        if (exp_q.size() == 0) begin
          check("start_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("start_data", 32'(bus.UartData_o), 32'(e.data));
          check("start_grant", 32'(bus.Grant_o), 32'(4'b0001 << e.req));
        end
      end
      if (bus.UartDone_i && bus.Grant_o != '0) ret_cyc = cyc + 1;
      if (bus.Timeout_o) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int widx;
    vecs[0] = '{4'b0101, 4'b0001};
    vecs[1] = '{4'b0101, 4'b0100};
    vecs[2] = '{4'b1111, 4'b1000};
    vecs[3] = '{4'b0110, 4'b0010};
    vecs[4] = '{4'b0010, 4'b0010};
    vecs[5] = '{4'b1001, 4'b1000};
    vecs[6] = '{4'b0011, 4'b0001};
    vecs[7] = '{4'b1110, 4'b0010};

    tick(); tick();
    check("rst_grant", 32'(bus.Grant_o), 32'd0);
    check("rst_ready", 32'(bus.Ready_o), 32'd0);
    check("rst_start", 32'(bus.UartStart_o), 32'd0);
    check("rst_data", 32'(bus.UartData_o), 32'd0);
    check("rst_timeout", 32'(bus.Timeout_o), 32'd0);
    Reset = 1'b1;
    tick();

    // Round-robin table: one-byte packets on each masked requester.
    for (int v = 0; v < 8; v++) begin
      widx = 0;
      for (int k = 0; k < N; k++) if (vecs[v].exp_grant[k]) widx = k;
      for (int k = 0; k < N; k++)
        if (vecs[v].mask[k]) rq[k].push_back({8'(16*v + k), 1'b1});
      exp_q.push_back({2'(widx), 8'(16*v + widx)});
      wait_grant($sformatf("rr_vec%0d_grant", v), vecs[v].exp_grant);
      for (int k = 0; k < N; k++) if (k != widx) rq[k].delete();
      wait_drain($sformatf("rr_vec%0d_drain", v));
    end

    // "Hi!" from requester 0.
    do_reset();
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b0);
    push(0, 8'h21, 1'b1);
    wait_grant("hi_grant", 4'b0001);
    wait_drain("hi_drain");

    // Requesters 0 and 2 request together from reset.
    do_reset();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0);
    push(2, 8'hC1, 1'b1);
    wait_grant("pair_first_grant", 4'b0001);
    wait_drain("pair_drain");

    // Requester 1 streams two packets while requester 3 waits.
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b1);
    exp_q.push_back({2'd3, 8'h30});
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b1);
    exp_q.push_back({2'd3, 8'h31});
    wait_grant("stream_first_grant", 4'b0010);
    rq[3].push_back({8'h30, 1'b1});
    rq[3].push_back({8'h31, 1'b1});
    wait_drain("stream_drain");

    // Lock timeout after a non-Last byte; requester 1 pending.
    base = to_cnt;
    push(0, 8'h5A, 1'b0);
    wait_grant("to_grant", 4'b0001);
    push(1, 8'h77, 1'b1);
    for (int i = 0; i < 200 && to_cnt == base; i++) tick();
    check("to_seen", 32'(to_cnt - base), 32'd1);
    check("to_delay", 32'(to_cyc - ret_cyc), 32'd16);
    check("to_grant_released", 32'(bus.Grant_o), 32'd0);
    wait_drain("to_drain");
    check("to_single_pulse", 32'(to_cnt - base), 32'd1);

    // Busy held high while the owner is valid.
    base = to_cnt;
    force_busy = 1'b1;
    push(2, 8'h3C, 1'b1);
    wait_grant("busy_grant", 4'b0100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("busy_ready", 32'(bus.Ready_o), 32'd0);
      check("busy_start", 32'(bus.UartStart_o), 32'd0);
    end
    check("busy_no_timeout", 32'(to_cnt - base), 32'd0);
    check("busy_grant_held", 32'(bus.Grant_o), 32'b0100);
    force_busy = 1'b0;
    #1;
    check("busy_release_ready", 32'(bus.Ready_o), 32'b0100);
    tick();
    check("busy_release_start", 32'(bus.UartStart_o), 32'd1);
    wait_drain("busy_drain");

    // Reset during requester 2's frame.
    push(2, 8'hD1, 1'b0);
    rq[2].push_back({8'hD2, 1'b1});
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("mid_start_seen", 32'(exp_q.size()), 32'd0);
    tick();
    Reset = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.Grant_o), 32'd0);
    check("mid_rst_ready", 32'(bus.Ready_o), 32'd0);
    check("mid_rst_start", 32'(bus.UartStart_o), 32'd0);
    check("mid_rst_data", 32'(bus.UartData_o), 32'd0);
    check("mid_rst_timeout", 32'(bus.Timeout_o), 32'd0);
    for (int k = 0; k < N; k++) rq[k].delete();
    exp_q.delete();
    tick(); tick();
    Reset = 1'b1;
    tick();
    push(0, 8'hB0, 1'b1);
    push(2, 8'hB2, 1'b1);
    wait_grant("post_rst_grant", 4'b0001);
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
